// File: rtl/next_buf_pkg.sv
// Shared defaults and helpers for the rotating frame buffer.
package next_buf_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_ADDR_WIDTH = 11;
   localparam int unsigned DEF_NUM_BANKS  = 2;

   // Width of a bank index; never narrower than one bit.
   function automatic int unsigned bank_idx_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/next_buf_dual_sram.sv
// One frame bank: port 1 synchronous read, port 2 write.
module next_buf_dual_sram #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cs1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic [DATA_WIDTH-1:0] dout1,
   input  logic                  cs2,
   input  logic [ADDR_WIDTH-1:0] addr2,
   input  logic [DATA_WIDTH-1:0] din2
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (cs2) mem[addr2] <= din2;
   end

   // Output register holds its value between reads; the array itself is never cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      dout1 <= '0;
      else if (cs1) dout1 <= mem[addr1];
   end

endmodule

// File: rtl/next_buf.sv
// Multi-bank frame buffer: producer fills and commits banks, consumer reads and releases them in order.
module next_buf
   import next_buf_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned NUM_BANKS  = DEF_NUM_BANKS
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wr_valid,
   output logic                             wr_ready,
   input  logic [ADDR_WIDTH-1:0]            wr_addr,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   input  logic                             wr_last,
   input  logic                             rd_req,
   input  logic [ADDR_WIDTH-1:0]            rd_addr,
   input  logic                             rd_last,
   output logic                             rd_avail,
   output logic [DATA_WIDTH-1:0]            rd_data,
   output logic                             rd_valid,
   output logic [$clog2(NUM_BANKS+1)-1:0]   full_cnt,
   output logic                             wr_err,
   output logic                             rd_err
);

   localparam int unsigned BANK_W = bank_idx_w(NUM_BANKS);
   localparam int unsigned CNT_W  = $clog2(NUM_BANKS + 1);

   logic [BANK_W-1:0]     wr_bank, rd_bank, rd_sel;
   logic                  wr_acc, rd_acc, commit, rel;
   logic [DATA_WIDTH-1:0] bank_dout [NUM_BANKS];

   function automatic logic [BANK_W-1:0] bank_inc(input logic [BANK_W-1:0] b);
      return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + BANK_W'(1);
   endfunction

   assign wr_ready = (full_cnt < CNT_W'(NUM_BANKS));
   assign rd_avail = (full_cnt != '0);
   assign wr_acc   = wr_valid & wr_ready;
   assign rd_acc   = rd_req & rd_avail;
   assign commit   = wr_acc & wr_last;
   assign rel      = rd_acc & rd_last;

   // Pointers, occupancy and status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_bank  <= '0;
         rd_bank  <= '0;
         rd_sel   <= '0;
         full_cnt <= '0;
         rd_valid <= 1'b0;
         wr_err   <= 1'b0;
         rd_err   <= 1'b0;
      end else begin
         if (commit) wr_bank <= bank_inc(wr_bank);
         if (rel)    rd_bank <= bank_inc(rd_bank);
         if (rd_acc) rd_sel  <= rd_bank;
         case ({commit, rel})
            2'b10:   full_cnt <= full_cnt + CNT_W'(1);
            2'b01:   full_cnt <= full_cnt - CNT_W'(1);
            default: full_cnt <= full_cnt;
         endcase
         rd_valid <= rd_acc;
         wr_err   <= wr_valid & ~wr_ready;
         rd_err   <= rd_req & ~rd_avail;
      end
   end

   for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
      next_buf_dual_sram #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_sram (
         .clk   (clk),
         .rst   (rst),
         .cs1   (rd_acc && (rd_bank == BANK_W'(b))),
         .addr1 (rd_addr),
         .dout1 (bank_dout[b]),
         .cs2   (wr_acc && (wr_bank == BANK_W'(b))),
         .addr2 (wr_addr),
         .din2  (wr_data)
      );
   end

   // rd_sel only moves on an accepted read, so rd_data holds between reads.
   assign rd_data = bank_dout[rd_sel];

endmodule

// File: tb/tb_next_buf.sv
// Randomized scoreboard bench for next_buf against a frame-queue reference model.
module tb_next_buf;

   localparam int unsigned DW    = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned NB    = 3;
   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned CW    = $clog2(NB + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_valid, wr_ready, wr_last;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          rd_req, rd_last, rd_avail, rd_valid;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [CW-1:0] full_cnt;
   logic          wr_err, rd_err;

   next_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB)) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_last(wr_last),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_last(rd_last),
      .rd_avail(rd_avail), .rd_data(rd_data), .rd_valid(rd_valid),
      .full_cnt(full_cnt), .wr_err(wr_err), .rd_err(rd_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            known;
      logic [DW-1:0] d;
   } exp_t;

   int            n_vec = 0;
   int            n_err = 0;
   exp_t          exp_q[$];
   logic [DW-1:0] last_data;

   // Reference: physical storage per bank plus frame accounting.
   logic [DW-1:0] mm [NB][DEPTH];
   bit            mv [NB][DEPTH];
   int            cnt, wr_b, rd_b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      cnt = 0; wr_b = 0; rd_b = 0;
      exp_q.delete();
      last_data = '0;
   endtask

   task automatic chk_status(input bit e_werr, input bit e_rerr);
      chk("full_cnt", 32'(full_cnt), 32'(cnt));
      chk("wr_ready", 32'(wr_ready), 32'(cnt < int'(NB)));
      chk("rd_avail", 32'(rd_avail), 32'(cnt > 0));
      chk("wr_err",   32'(wr_err),   32'(e_werr));
      chk("rd_err",   32'(rd_err),   32'(e_rerr));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_clear();
      chk_status(1'b0, 1'b0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data",  32'(rd_data),  32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // One clock of stimulus; expectations are pushed after the edge that accepts the read.
   task automatic cycle(input bit wv, input int wa, input int wd, input bit wl,
                        input bit rq, input int ra, input bit rl);
      bit   wacc, racc, e_werr, e_rerr;
      exp_t e;
      wr_valid = wv; wr_addr = AW'(wa); wr_data = DW'(wd); wr_last = wl;
      rd_req   = rq; rd_addr = AW'(ra); rd_last = rl;
      wacc   = wv && (cnt < int'(NB));
      racc   = rq && (cnt > 0);
      e_werr = wv && !wacc;
      e_rerr = rq && (cnt == 0);
      if (racc) begin
         e.known = mv[rd_b][ra];
         e.d     = mm[rd_b][ra];
      end
      @(posedge clk); #1;
      if (racc) exp_q.push_back(e);
      if (wacc) begin
         mm[wr_b][wa] = DW'(wd);
         mv[wr_b][wa] = 1'b1;
         if (wl) begin wr_b = (wr_b + 1) % int'(NB); cnt++; end
      end
      if (racc && rl) begin rd_b = (rd_b + 1) % int'(NB); cnt--; end
      chk_status(e_werr, e_rerr);
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: pops one expectation per returned word, checks hold otherwise.
   always @(negedge clk) begin
      if (!rst) begin
         chk("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (rd_valid) begin
               if (e.known) begin
                  chk("rd_data", 32'(rd_data), 32'(e.d));
                  last_data = e.d;
               end else begin
                  last_data = rd_data;
               end
            end
         end else if (!rd_valid) begin
            chk("rd_data_hold", 32'(rd_data), 32'(last_data));
         end
      end
   end

   initial begin
      wr_valid = 0; wr_addr = '0; wr_data = '0; wr_last = 0;
      rd_req = 0; rd_addr = '0; rd_last = 0;
      for (int b = 0; b < int'(NB); b++)
         for (int a = 0; a < int'(DEPTH); a++) mv[b][a] = 1'b0;
      model_clear();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Basic frame: A0..A3, then read address 2.
      for (int a = 0; a < 4; a++) cycle(1, a, 'hA0 + a, a == 3, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 2, 0);
      idle();

      // Release, then read while empty.
      cycle(0, 0, 0, 0, 1, 0, 1);
      idle();
      cycle(0, 0, 0, 0, 1, 1, 0);
      idle();

      // Commit and release in the same cycle.
      cycle(1, 0, 'h55, 1, 0, 0, 0);
      cycle(1, 0, 'h66, 1, 1, 0, 1);
      cycle(0, 0, 0, 0, 1, 0, 1);
      idle();

      // Fill every bank, attempt an overflow write, then drain.
      for (int f = 0; f < int'(NB); f++) cycle(1, 0, 'hF0 + f, 1, 0, 0, 0);
      cycle(1, 0, 'hFF, 1, 0, 0, 0);
      idle();
      for (int f = 0; f < int'(NB); f++) cycle(0, 0, 0, 0, 1, 0, 1);
      idle();

      // Seven frames through three banks, pointers wrap.
      for (int k = 0; k < 7; k++) begin
         for (int a = 0; a < 4; a++) cycle(1, a, 'h100 + k, a == 3, 0, 0, 0);
         for (int a = 0; a < 4; a++) cycle(0, 0, 0, 0, 1, a, a == 3);
      end
      idle();

      // Random traffic.
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 16'hFFFF),
               $urandom_range(0, 3) == 0, $urandom_range(0, 1),
               $urandom_range(0, DEPTH - 1), $urandom_range(0, 3) == 0);
      for (int i = 0; i < int'(NB) && cnt > 0; i++) cycle(0, 0, 0, 0, 1, 0, 1);
      idle();
      idle();

      // Reset during a partial frame with one frame committed.
      cycle(1, 0, 'h77, 1, 0, 0, 0);
      cycle(1, 1, 'h78, 0, 0, 0, 0);
      wr_valid = 0;
      do_reset();
      idle();
      cycle(0, 0, 0, 0, 1, 0, 0);
      idle();

      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
